key_pulse_gen: RTL and testbench
================================

# key_pulse_gen

Conditions one raw push-button (e.g. KEY0) into clean, clock-synchronous events: 2-FF synchronizer, debounce FSM, and single-cycle press/release pulses, plus long-press and auto-repeat pulses. It sits directly upstream of the TIME/DATE display selector, whose `sel_p` input is driven by `press_p`. The long-press and auto-repeat outputs drive the time/date set logic.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles the level must be stable to accept a press or release (20 ms at 50 MHz); minimum 2.
- `LONG_CYCLES`, default 50_000_000: debounced hold time before `long_p` fires (1 s); minimum 2.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period after a long press (200 ms); minimum 2.
- `KEY_ACTIVE_LOW`, default 1: 1 means a raw 0 is pressed (DE-board keys).

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_in`  in  1  raw asynchronous button.
- `press_p`  out  1  one-cycle pulse on an accepted press.
- `release_p`  out  1  one-cycle pulse on an accepted release.
- `long_p`  out  1  one-cycle pulse once per press, after `LONG_CYCLES` of hold.
- `rep_p`  out  1  one-cycle pulse every `REPEAT_CYCLES` while in long hold.
- `key_level`  out  1  debounced pressed level.

## Operation
- Synchronizer: 2 flops. `k = sync2 XOR KEY_ACTIVE_LOW`, so `k=1` means pressed. On reset both flops load the released raw level.
- Shared `cnt` (debounce) plus `hold_cnt` (long/repeat). Width is `$clog2` of the largest parameter. All comparisons are equality against PARAM-1, so counters never wrap.
- States:
  - **IDLE**: if `k`, go to **DB_PRESS** with `cnt=0`.
  - **DB_PRESS**:
    - if `!k`, go to **IDLE** (bounce rejected, no output);
    - else if `cnt==DEBOUNCE_CYCLES-1`, go to **HELD**, pulse `press_p`, set `key_level=1`, `hold_cnt=0`;
    - else `cnt++`.
  - **HELD**:
    - if `!k`, go to **DB_REL** with `cnt=0`, `was_long=0`;
    - else if `hold_cnt==LONG_CYCLES-1`, go to **LONG**, pulse `long_p`, `hold_cnt=0`;
    - else `hold_cnt++`.
  - **LONG**:
    - if `!k`, go to **DB_REL** with `cnt=0`, `was_long=1`;
    - else if `hold_cnt==REPEAT_CYCLES-1`, pulse `rep_p`, `hold_cnt=0`;
    - else `hold_cnt++`.
  - **DB_REL**:
    - if `k`, return to HELD or LONG per `was_long`; `hold_cnt` is frozen, not cleared;
    - else if `cnt==DEBOUNCE_CYCLES-1`, go to **IDLE**, pulse `release_p`, set `key_level=0`;
    - else `cnt++`.
- `hold_cnt` increments only on edges where the state is HELD or LONG and `k=1`. A release glitch therefore delays long/repeat by the cycles spent outside those states.
- `long_p` fires at most once per accepted press. `rep_p` never fires before `long_p`.
- All pulse outputs are registered, high for exactly one cycle, and mutually exclusive.

## Timing
- Reset value of every output is 0. State resets to IDLE and all counters to 0.
- Edge numbering: edge 1 is the first rising edge sampling a new stable `key_in`.
  - `k` is visible after edge 2.
  - DB_PRESS is entered at edge 3.
  - `press_p` and `key_level` rise at edge `3+DEBOUNCE_CYCLES`.
- Release timing mirrors press: `release_p` at edge `3+DEBOUNCE_CYCLES` after the release edge 1.
- `long_p` fires `LONG_CYCLES` edges after `press_p`. The first `rep_p` fires `REPEAT_CYCLES` edges after `long_p`, then periodically.
- Reset mid-operation:
  - Outputs go to 0 on the reset edge.
  - No `release_p` is generated.
  - A key still held after reset deassertion produces a fresh `press_p` `3+DEBOUNCE_CYCLES` edges after the first non-reset edge.

## Structure
- Package `key_pkg`:
  - state enum `key_state_t` (IDLE, DB_PRESS, HELD, LONG, DB_REL);
  - 50 MHz default cycle constants used as parameter defaults.
- One sub-module, `sync_2ff` (parameterized reset value), instantiated for `key_in`.
- Top-level wiring: `press_p` goes to the selector's `sel_p`.

## Test plan
Common parameters: `DEBOUNCE_CYCLES=4`, `LONG_CYCLES=10`, `REPEAT_CYCLES=3`, `KEY_ACTIVE_LOW=1`.

1. Reset, then `key_in` driven 0 from edge 1 onward -> `press_p=1` only at edge 7; `key_level` is 1 from edge 7; nothing else fires.
2. `key_in` low for 2 cycles then high (bounce) -> all outputs stay 0 throughout.
3. Hold continuously -> `press_p` @7, `long_p` @17, `rep_p` @20, 23, 26. Release at edge 30 -> `release_p` @36, no `rep_p` after DB_REL is entered.
4. During HELD, `key_in` high for 2 cycles then low again -> no `release_p`; `key_level` stays 1; `long_p` is delayed by 3 edges (2 glitch edges + return edge) to @20.
5. Assert `rst` for 1 cycle while in LONG with key held -> all outputs 0 on that edge, no `release_p`; `press_p` again 7 edges after `rst` drops (first non-reset edge = edge 1).
6. Press, long-press, release, re-press -> second press gives exactly one `press_p`, and `long_p` only after a fresh `LONG_CYCLES` (`hold_cnt` cleared by IDLE).

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and 50 MHz default timing constants for the push-button conditioner.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    HELD     = 3'd2,
    LONG     = 3'd3,
    DB_REL   = 3'd4
  } key_state_t;

  // Cycle counts for a 50 MHz system clock.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
  localparam int unsigned DEF_LONG_CYCLES     = 50_000_000;  // 1 s
  localparam int unsigned DEF_REPEAT_CYCLES   = 10_000_000;  // 200 ms

  // Largest of three cycle counts; sizes the shared counters.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a selectable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s_p0;
  logic s_p1;

  // Shift the raw input through two flops; reset loads the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_p0 <= RST_VAL;
      s_p1 <= RST_VAL;
    end else begin
      s_p0 <= d;
      s_p1 <= s_p0;
    end
  end

  assign q = s_p1;

endmodule

// File: rtl/key_pulse_gen.sv
// Push-button conditioner: synchronizer, debounce FSM, press/release/long/repeat pulses.
// press_p feeds the TIME/DATE selector's sel_p; long_p and rep_p feed the set logic.
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic press_p,
  output logic release_p,
  output logic long_p,
  output logic rep_p,
  output logic key_level
);

  localparam int unsigned MAX_CYC = max3(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
  localparam int          CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Terminal values; counters stop at these and are reloaded, so they never wrap.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             key_sync;
  logic             k;
  key_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             was_long, was_long_nxt;
  logic             press_nxt, release_nxt, long_nxt, rep_nxt, level_nxt;

  // Reset loads the released raw level so a held key is re-detected after reset.
  sync_2ff #(
    .RST_VAL (KEY_ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_sync)
  );

  // k = 1 means pressed regardless of board polarity.
  assign k = key_sync ^ KEY_ACTIVE_LOW;

  // Next-state, counter and pulse decode; pulses are registered below.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    hold_nxt     = hold_cnt;
    was_long_nxt = was_long;
    press_nxt    = 1'b0;
    release_nxt  = 1'b0;
    long_nxt     = 1'b0;
    rep_nxt      = 1'b0;
    level_nxt    = key_level;
    case (state)
      IDLE: begin
        hold_nxt = '0;
        if (k) begin
          state_nxt = DB_PRESS;
          cnt_nxt   = '0;
        end
      end
      DB_PRESS: begin
        if (!k) begin
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
          level_nxt = 1'b1;
          hold_nxt  = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!k) begin
          state_nxt    = DB_REL;
          cnt_nxt      = '0;
          was_long_nxt = 1'b0;
        end else if (hold_cnt == LONG_LAST) begin
          state_nxt = LONG;
          long_nxt  = 1'b1;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      LONG: begin
        if (!k) begin
          state_nxt    = DB_REL;
          cnt_nxt      = '0;
          was_long_nxt = 1'b1;
        end else if (hold_cnt == REP_LAST) begin
          rep_nxt  = 1'b1;
          hold_nxt = '0;
        end else begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      DB_REL: begin
        // A release glitch resumes the hold phase with hold_cnt frozen.
        if (k) begin
          state_nxt = was_long ? LONG : HELD;
        end else if (cnt == DB_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          level_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_cnt  <= '0;
      was_long  <= 1'b0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
      rep_p     <= 1'b0;
      key_level <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold_cnt  <= hold_nxt;
      was_long  <= was_long_nxt;
      press_p   <= press_nxt;
      release_p <= release_nxt;
      long_p    <= long_nxt;
      rep_p     <= rep_nxt;
      key_level <= level_nxt;
    end
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: directed run-length vector table plus randomized key activity
// checked against a run-length/hold-time reference model.
module tb_key_pulse_gen;

  localparam int DB  = 4;
  localparam int LC  = 10;
  localparam int RC  = 3;
  localparam bit KAL = 1'b1;

  // Output vector layout: {press_p, release_p, long_p, rep_p, key_level}
  localparam logic [4:0] PR = 5'b10000;
  localparam logic [4:0] RL = 5'b01000;
  localparam logic [4:0] LG = 5'b00100;
  localparam logic [4:0] RP = 5'b00010;
  localparam logic [4:0] LV = 5'b00001;
  localparam logic [4:0] NO = 5'b00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in = 1'b1;
  logic press_p, release_p, long_p, rep_p, key_level;

  key_pulse_gen #(
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LC),
    .REPEAT_CYCLES   (RC),
    .KEY_ACTIVE_LOW  (KAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .press_p   (press_p),
    .release_p (release_p),
    .long_p    (long_p),
    .rep_p     (rep_p),
    .key_level (key_level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int unsigned reps;
    bit          r;
    bit          k;
    logic [4:0]  exp;
  } row_t;

  row_t tbl[$];

  function automatic void add(input int unsigned reps, input bit r, input bit k,
                              input logic [4:0] e);
    row_t x;
    x.reps = reps; x.r = r; x.k = k; x.exp = e;
    tbl.push_back(x);
  endfunction

  // Reference model: the key is seen two edges late; the debounced level flips once the
  // opposite level has been seen on DB+1 consecutive edges; long/repeat are counted in
  // "hold edges" (pressed, key seen pressed, no release in progress) since the press.
  bit         m_d1, m_d2, m_level;
  int         m_run, m_q;
  logic [4:0] m_out;

  task automatic model_edge(input bit r, input bit kin);
    bit k;
    if (r) begin
      m_d1 = 1'b0; m_d2 = 1'b0; m_level = 1'b0;
      m_run = 0; m_q = 0; m_out = '0;
      return;
    end
    k = m_d2;
    m_d2 = m_d1;
    m_d1 = (kin != KAL);
    m_out = '0;
    if (!m_level) begin
      if (k) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_level = 1'b1; m_run = 0; m_q = 0; m_out[4] = 1'b1;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (!k) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_level = 1'b0; m_run = 0; m_out[3] = 1'b1;
        end
      end else begin
        if (m_run == 0) begin
          m_q++;
          if (m_q == LC) m_out[2] = 1'b1;
          else if (m_q > LC && ((m_q - LC) % RC) == 0) m_out[1] = 1'b1;
        end
        m_run = 0;
      end
    end
    m_out[0] = m_level;
  endtask

  task automatic drive(input bit r, input bit kin);
    rst = r;
    key_in = kin;
    @(posedge clk);
    model_edge(r, kin);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [4:0] exp);
    logic [4:0] got;
    got = {press_p, release_p, long_p, rep_p, key_level};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: {press,release,long,rep,level} got %b expected %b",
               name, idx, got, exp);
    end
  endtask

  initial begin
    // Hold continuously: press, long, repeats, then release.
    add(2, 1, 1, NO);
    add(6, 0, 0, NO);
    add(1, 0, 0, PR | LV);
    add(9, 0, 0, LV);
    add(1, 0, 0, LG | LV);
    for (int i = 0; i < 4; i++) begin
      add(2, 0, 0, LV);
      add(1, 0, 0, RP | LV);
    end
    add(6, 0, 1, LV);
    add(1, 0, 1, RL);
    add(3, 0, 1, NO);
    // Re-press: fresh long timing, one repeat, then release.
    add(6, 0, 0, NO);
    add(1, 0, 0, PR | LV);
    add(9, 0, 0, LV);
    add(1, 0, 0, LG | LV);
    add(2, 0, 0, LV);
    add(1, 0, 0, RP | LV);
    add(6, 0, 1, LV);
    add(1, 0, 1, RL);
    add(2, 0, 1, NO);
    // Bounce shorter than the debounce window.
    add(2, 1, 1, NO);
    add(2, 0, 0, NO);
    add(8, 0, 1, NO);
    // Release glitch during HELD delays long_p by 3 edges.
    add(2, 1, 1, NO);
    add(6, 0, 0, NO);
    add(1, 0, 0, PR | LV);
    add(2, 0, 0, LV);
    add(2, 0, 1, LV);
    add(8, 0, 0, LV);
    add(1, 0, 0, LG | LV);
    add(2, 0, 0, LV);
    // Reset while in LONG with key held: no release, fresh press afterwards.
    add(1, 1, 0, NO);
    add(6, 0, 0, NO);
    add(1, 0, 0, PR | LV);
    add(3, 0, 0, LV);
    add(6, 0, 1, LV);
    add(1, 0, 1, RL);
    add(2, 0, 1, NO);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int j = 0; j < int'(tbl[i].reps); j++) begin
        drive(tbl[i].r, tbl[i].k);
        check("dir_row", i, tbl[i].exp);
      end
    end

    // Randomized key activity with occasional resets, against the model.
    drive(1'b1, 1'b1);
    check("rand_reset", 0, m_out);
    begin
      int e;
      e = 0;
      while (e < 3000) begin
        int len;
        bit kin;
        len = int'($urandom_range(1, 40));
        kin = 1'($urandom_range(0, 1));
        for (int j = 0; j < len; j++) begin
          bit r;
          r = ($urandom_range(0, 199) == 0);
          drive(r, kin);
          check("rand", e, m_out);
          e++;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
